mcu_cmd_fifo_regs: RTL
======================

// Module: mcu_cmd_fifo_regs
// PURPOSE
//  Register-bank stage directly downstream of the MCU async memory bus bridge.
//  Consumes the bridge's addr/write/wrdata and returns rddata.
//  Assembles 32-bit motion commands from two 16-bit MCU writes and buffers them in a FIFO.
//  Presents buffered commands to the step generator over a valid/ready stream.
// PARAMETERS
//  ADDR_BASE   16'h0040  word address of DATA_LO; block decodes ADDR_BASE..ADDR_BASE+3
//  DEPTH       16        FIFO entries; power of 2, 4..256
//  AFULL_LVL   12        almost-full threshold (used only with CMD_FIFO_ALMOST_EN)
// PORTS
//  clk          in   1   system clock, same clock as the bus bridge
//  aclr_n       in   1   asynchronous reset, active low
//  addr         in   16  word address from bus bridge
//  write        in   1   bridge write level; high for several clk per MCU write
//  wrdata       in   16  write data from bus bridge
//  rddata       out  16  read data to bus bridge, registered
//  cmd_valid    out  1   FIFO head valid (FIFO not empty)
//  cmd_ready    in   1   consumer accepts head when cmd_valid & cmd_ready
//  cmd_data     out  32  FIFO head {hi,lo}
//  almost_full  out  1   only with CMD_FIFO_ALMOST_EN
// BEHAVIOUR
//  - Reset (aclr_n low, async): rddata=0, FIFO empty, cmd_valid=0, cmd_data=0.
//    Also clears: lo latch=0, overflow=0, write_q=0, almost_full=0.
//  - Write strobe: wr_stb = write & !write_q, with write_q = write delayed 1 clk.
//    Exactly one strobe per MCU write. addr and wrdata are sampled on the wr_stb cycle.
//  - Register map, word offsets from ADDR_BASE:
//    +0 DATA_LO  W: lo latch <= wrdata.  R: lo latch.
//    +1 DATA_HI  W: push {wrdata, lo latch}.  R: 16'h0000.
//    +2 STATUS   R: [15]=overflow, [14]=full, [13]=empty, [12]=almost_full or 0,
//                   [8:0]=level zero-extended.
//                W: bit15=1 clears overflow; bit0=1 flushes the FIFO.
//    +3 ID       R: 16'hC3F0.  W: ignored.
//    Any other address: R 16'h0000, W ignored.
//  - Read: rddata <= decode(addr) every clk; latency 1 clk; reads have no side effects.
//  - FIFO: first-word-fall-through.
//    cmd_data = mem[rd_ptr], valid while cmd_valid, held stable until the pop.
//    Pop = cmd_valid & cmd_ready.
//    Pointers are $clog2(DEPTH) bits and wrap naturally; level is $clog2(DEPTH)+1 bits.
//    full = (level==DEPTH); empty = (level==0).
//  - Push latency: DATA_HI strobe in cycle N -> entry visible and cmd_valid=1 in N+1.
//  - Push while full: data dropped, overflow set sticky.
//    Full is evaluated before the same-cycle pop, so push+pop at full still drops and sets overflow.
//  - Push+pop same cycle, not full: both occur, level unchanged.
//  - Pop while empty: impossible by definition, because cmd_valid=0.
//  - Flush: pointers and level cleared on the strobe cycle; cmd_valid=0 in N+1.
//    The lo latch is not cleared.
//    The same STATUS write may also clear overflow (bits 15 and 0 both set).
//    A same-cycle pop is discarded by the flush.
//  - Overflow set and clear in the same cycle: impossible, because they are different registers (+1 vs +2).
//  - aclr_n asserted mid-operation: all state clears immediately; FIFO contents are lost.
//    cmd_valid drops asynchronously.
// CONFIGURATION
//  CMD_FIFO_ALMOST_EN defined:
//    almost_full port present; almost_full <= (level >= AFULL_LVL), registered.
//    STATUS[12] reflects almost_full.
//  CMD_FIFO_ALMOST_EN undefined:
//    no almost_full port; STATUS[12] reads 0; AFULL_LVL unused.
// TESTING
//  1. Reset, then read ID and STATUS
//     -> 16'hC3F0; STATUS=16'h2000 (empty, level 0, 1 clk read latency).
//  2. Write LO=16'h1234, HI=16'hABCD, cmd_ready=0
//     -> cmd_valid=1 at N+1, cmd_data=32'hABCD1234, STATUS level=1.
//     Hold write high 5 clk -> still one entry.
//  3. Fill DEPTH entries, one more HI write
//     -> full=1, overflow=1, level stays DEPTH.
//     Drain with cmd_ready=1 -> DEPTH words out in order, last value not the dropped one.
//  4. FIFO with 3 entries, HI write in the same cycle as a pop -> level stays 3.
//     Write STATUS=16'h8001 -> level 0, cmd_valid=0, overflow=0.
//  5. Assert aclr_n low mid-drain, with cmd_valid=1 and level=5
//     -> cmd_valid=0 immediately; after release STATUS=16'h2000.
//  6. With CMD_FIFO_ALMOST_EN, push 11 then 12 entries
//     -> almost_full 0 then 1 one clk after the 12th push; STATUS[12] matches.

Source files
------------

// File: rtl/mcu_cmd_fifo_regs.sv
// mcu_cmd_fifo_regs
//   Register bank behind the MCU async memory bus bridge. It assembles 32-bit
//   motion commands from two 16-bit MCU writes (DATA_LO, then DATA_HI). It
//   buffers the commands in a first-word-fall-through FIFO and hands them to
//   the step generator over a valid/ready stream.
//
//   Optional feature macro: CMD_FIFO_ALMOST_EN
//   When it is defined, the almost_full port exists and STATUS[12] reflects it.
//
// Ports
//   clk          system clock (same clock as the bus bridge)
//   aclr_n       asynchronous reset, active low
//   addr         word address from the bridge
//   write        bridge write level; high for several clk per MCU write
//   wrdata       write data from the bridge
//   rddata       registered read data to the bridge (1 clk latency)
//   almost_full  level >= AFULL_LVL (only with CMD_FIFO_ALMOST_EN)
//   cmd_valid    FIFO not empty
//   cmd_ready    consumer accepts the head when cmd_valid & cmd_ready
//   cmd_data     FIFO head {hi, lo}; 0 while empty
//
// Register map (word offsets from ADDR_BASE)
//   +0 DATA_LO  R/W lo latch
//   +1 DATA_HI  W pushes {wrdata, lo latch}; R 0
//   +2 STATUS   R {ovf, full, empty, afull, 3'b0, level[8:0]}
//               W bit15 clears overflow, bit0 flushes the FIFO
//   +3 ID       R 16'hC3F0
module mcu_cmd_fifo_regs #(
   parameter logic [15:0] ADDR_BASE = 16'h0040,
   parameter int          DEPTH     = 16,
   parameter int          AFULL_LVL = 12
) (
   input  logic        clk,
   input  logic        aclr_n,
   input  logic [15:0] addr,
   input  logic        write,
   input  logic [15:0] wrdata,
   output logic [15:0] rddata,
`ifdef CMD_FIFO_ALMOST_EN
   output logic        almost_full,
`endif
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [31:0] cmd_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [LW-1:0] LVL_ONE = LW'(1);
   localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0] level_reg, level_next;
   logic [15:0]   lo_reg;
   logic          overflow_reg;
   logic          write_q_reg;
   logic          afull_flag;

   // Address decode relative to the block base; out-of-range offsets miss.
   logic [15:0] offset;
   logic        in_range;
   logic        wr_stb;
   logic        sel_lo, sel_hi, sel_st;
   logic        full, empty;
   logic        push, pop, flush;

   assign offset   = addr - ADDR_BASE;
   assign in_range = (offset[15:2] == 14'd0);

   // The bridge holds write high for several clocks; strobe only on its rise.
   assign wr_stb = write & ~write_q_reg;
   assign sel_lo = wr_stb & in_range & (offset[1:0] == 2'd0);
   assign sel_hi = wr_stb & in_range & (offset[1:0] == 2'd1);
   assign sel_st = wr_stb & in_range & (offset[1:0] == 2'd2);

   assign full  = (level_reg == LVL_MAX);
   assign empty = (level_reg == '0);

   // Full is judged before the same-cycle pop, so push+pop at full still drops.
   assign push  = sel_hi & ~full;
   assign pop   = cmd_valid & cmd_ready;
   assign flush = sel_st & wrdata[0];

   assign cmd_valid = ~empty;
   assign cmd_data  = cmd_valid ? mem[rd_ptr_reg] : 32'h0000_0000;

   always_comb begin
      level_next = level_reg;
      if (flush)
         level_next = '0;
      else if (push & ~pop)
         level_next = level_reg + LVL_ONE;
      else if (pop & ~push)
         level_next = level_reg - LVL_ONE;
   end

`ifdef CMD_FIFO_ALMOST_EN
   // Registered from level_next so the flag lines up with the level it describes.
   logic afull_reg;
   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n)
         afull_reg <= 1'b0;
      else
         afull_reg <= (level_next >= LW'(AFULL_LVL));
   end
   assign afull_flag  = afull_reg;
   assign almost_full = afull_reg;
`else
   // The threshold has no effect in this build; it stays in the parameter list
   // so that both builds share one instantiation template.
   logic unused_afull_lvl;
   assign unused_afull_lvl = |AFULL_LVL;
   assign afull_flag = 1'b0;
`endif

   // Storage has no reset; reset empties the FIFO through the pointers and the level.
   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr_reg] <= {wrdata, lo_reg};
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         lo_reg       <= 16'h0000;
         overflow_reg <= 1'b0;
         write_q_reg  <= 1'b0;
      end else begin
         write_q_reg <= write;
         level_reg   <= level_next;
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         if (sel_lo)
            lo_reg <= wrdata;
         if (sel_hi & full)
            overflow_reg <= 1'b1;
         else if (sel_st & wrdata[15])
            overflow_reg <= 1'b0;
      end
   end

   // Reads have no side effects: decode the current state every clock.
   logic [15:0] status_word;
   logic [15:0] rd_word;
   assign status_word = {overflow_reg, full, empty, afull_flag, 3'b000, 9'(level_reg)};

   always_comb begin
      rd_word = 16'h0000;
      if (in_range) begin
         case (offset[1:0])
            2'd0:    rd_word = lo_reg;
            2'd2:    rd_word = status_word;
            2'd3:    rd_word = 16'hC3F0;
            default: rd_word = 16'h0000;
         endcase
      end
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n)
         rddata <= 16'h0000;
      else
         rddata <= rd_word;
   end

endmodule
